// File: rtl/wb_dual_slave_mux_if.sv
// Bus bundle for wb_dual_slave_mux: upstream Wishbone master port, two downstream
// slave ports and the timeout pulse. 'slave' is the mux view, 'master' the driver view.
interface wb_dual_slave_mux_if;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  logic        s0_cyc_o, s0_stb_o, s0_we_o;
  logic [3:0]  s0_sel_o;
  logic [31:0] s0_adr_o, s0_dat_o;
  logic        s0_ack_i;
  logic [31:0] s0_dat_i;

  logic        s1_cyc_o, s1_stb_o, s1_we_o;
  logic [3:0]  s1_sel_o;
  logic [31:0] s1_adr_o, s1_dat_o;
  logic        s1_ack_i;
  logic [31:0] s1_dat_i;

  logic        timeout_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output s0_cyc_o, s0_stb_o, s0_we_o, s0_sel_o, s0_adr_o, s0_dat_o,
    input  s0_ack_i, s0_dat_i,
    output s1_cyc_o, s1_stb_o, s1_we_o, s1_sel_o, s1_adr_o, s1_dat_o,
    input  s1_ack_i, s1_dat_i,
    output timeout_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  s0_cyc_o, s0_stb_o, s0_we_o, s0_sel_o, s0_adr_o, s0_dat_o,
    output s0_ack_i, s0_dat_i,
    input  s1_cyc_o, s1_stb_o, s1_we_o, s1_sel_o, s1_adr_o, s1_dat_o,
    output s1_ack_i, s1_dat_i,
    input  timeout_o
  );
endinterface

// File: rtl/wb_dual_slave_mux.sv
// Wishbone 1-to-2 address-decoding mux with registered slave requests and registered response.
// Define WB_MUX_TIMEOUT_EN to add an 8-bit ACTIVE-state timeout (TIMEOUT cycles, 1..255).

module wb_mux_slv_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drop,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] adr,
  input  logic [31:0] dat,
  output logic        req_cyc,
  output logic        req_stb,
  output logic        req_we,
  output logic [3:0]  req_sel,
  output logic [31:0] req_adr,
  output logic [31:0] req_dat
);
  // Request fields hold their last value after a drop; only cyc/stb are released.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_cyc <= 1'b0;
      req_stb <= 1'b0;
      req_we  <= 1'b0;
      req_sel <= '0;
      req_adr <= '0;
      req_dat <= '0;
    end else if (load) begin
      req_cyc <= 1'b1;
      req_stb <= 1'b1;
      req_we  <= we;
      req_sel <= sel;
      req_adr <= adr;
      req_dat <= dat;
    end else if (drop) begin
      req_cyc <= 1'b0;
      req_stb <= 1'b0;
    end
  end
endmodule

module wb_dual_slave_mux #(
  parameter logic [31:0] SLV0_BASE = 32'h3000_0000,
  parameter logic [31:0] SLV1_BASE = 32'h3010_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFF0_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_dual_slave_mux_if.slave bus
);
  localparam logic [31:0] MISS_DAT = 32'hBADA_DD00;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_dual_slave_mux: TIMEOUT must be within 1..255");
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              hit0, hit1;
  logic [1:0]        load, drop, slv_ack;
  logic [1:0][31:0]  slv_dat;
  logic [1:0]        p_cyc, p_stb, p_we;
  logic [1:0][3:0]   p_sel;
  logic [1:0][31:0]  p_adr, p_dat;
  logic [31:0]       resp_dat, dat_q;
  logic              ack_q;

  assign hit0    = (bus.wbs_adr_i & ADDR_MASK) == (SLV0_BASE & ADDR_MASK);
  assign hit1    = (bus.wbs_adr_i & ADDR_MASK) == (SLV1_BASE & ADDR_MASK);
  assign slv_ack = {bus.s1_ack_i, bus.s0_ack_i};
  assign slv_dat = {bus.s1_dat_i, bus.s0_dat_i};

`ifdef WB_MUX_TIMEOUT_EN
  localparam logic [31:0] TMO_DAT = 32'hDEAD_BEEF;
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt_q;
  logic       to_hit, to_fire, to_q;

  // to_cnt_q counts completed ACTIVE cycles, so to_hit marks the TIMEOUT-th one.
  assign to_hit = (to_cnt_q == TO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      to_cnt_q <= 8'd0;
      to_q     <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == ACTIVE && state_d == ACTIVE) ? to_cnt_q + 8'd1 : 8'd0;
      to_q     <= to_fire;
    end
  end
  assign bus.timeout_o = to_q;
`else
  assign bus.timeout_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    load     = '0;
    drop     = '0;
    resp_dat = '0;
`ifdef WB_MUX_TIMEOUT_EN
    to_fire  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          if (hit0) begin
            load[0] = 1'b1;
            sel_d   = 1'b0;
            state_d = ACTIVE;
          end else if (hit1) begin
            load[1] = 1'b1;
            sel_d   = 1'b1;
            state_d = ACTIVE;
          end else begin
            resp_dat = MISS_DAT;
            state_d  = RESP;
          end
        end
      end
      ACTIVE: begin
        // Master abort beats a same-cycle ack; ack beats a same-cycle timeout.
        if (!bus.wbs_cyc_i) begin
          drop[sel_q] = 1'b1;
          state_d     = IDLE;
        end else if (slv_ack[sel_q]) begin
          drop[sel_q] = 1'b1;
          resp_dat    = slv_dat[sel_q];
          state_d     = RESP;
        end
`ifdef WB_MUX_TIMEOUT_EN
        else if (to_hit) begin
          drop[sel_q] = 1'b1;
          resp_dat    = TMO_DAT;
          to_fire     = 1'b1;
          state_d     = RESP;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response is registered on RESP entry, so data is naturally zero outside the ack cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ack_q   <= (state_d == RESP);
      dat_q   <= resp_dat;
    end
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;

  for (genvar k = 0; k < 2; k++) begin : g_port
    wb_mux_slv_port u_port (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .load    (load[k]),
      .drop    (drop[k]),
      .we      (bus.wbs_we_i),
      .sel     (bus.wbs_sel_i),
      .adr     (bus.wbs_adr_i),
      .dat     (bus.wbs_dat_i),
      .req_cyc (p_cyc[k]),
      .req_stb (p_stb[k]),
      .req_we  (p_we[k]),
      .req_sel (p_sel[k]),
      .req_adr (p_adr[k]),
      .req_dat (p_dat[k])
    );
  end

  assign bus.s0_cyc_o = p_cyc[0];
  assign bus.s0_stb_o = p_stb[0];
  assign bus.s0_we_o  = p_we[0];
  assign bus.s0_sel_o = p_sel[0];
  assign bus.s0_adr_o = p_adr[0];
  assign bus.s0_dat_o = p_dat[0];
  assign bus.s1_cyc_o = p_cyc[1];
  assign bus.s1_stb_o = p_stb[1];
  assign bus.s1_we_o  = p_we[1];
  assign bus.s1_sel_o = p_sel[1];
  assign bus.s1_adr_o = p_adr[1];
  assign bus.s1_dat_o = p_dat[1];
endmodule

// File: tb/tb_wb_dual_slave_mux.sv
// Scoreboard bench for wb_dual_slave_mux: stimulus pushes expected slave requests and
// master responses; slave-model and monitor processes pop and compare. Honors WB_MUX_TIMEOUT_EN.
module tb_wb_dual_slave_mux;
  localparam logic [31:0] S0B   = 32'h3000_0000;
  localparam logic [31:0] S1B   = 32'h3010_0000;
  localparam logic [31:0] MASK  = 32'hFFF0_0000;
  localparam int          TMO   = 8;
  localparam logic [31:0] SALT0 = 32'h0F0F_1234;
  localparam logic [31:0] SALT1 = 32'h7E57_C0DE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_dual_slave_mux_if bus();

  wb_dual_slave_mux #(
    .SLV0_BASE(S0B), .SLV1_BASE(S1B), .ADDR_MASK(MASK), .TIMEOUT(TMO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  typedef struct { logic [31:0] dat; logic to; } resp_t;
  typedef struct { int k; logic we; logic [3:0] sel; logic [31:0] adr; logic [31:0] dat; } req_t;
  resp_t rq[$];
  req_t  sq[$];

  logic        m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_adr = '0, m_dat = '0;
  logic [1:0]  s_ack = '0, spur = '0;
  logic [31:0] s_dat [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
  int          lat [2] = '{0, 0};
  int          stb_run [2] = '{0, 0};

  assign bus.wbs_cyc_i = m_cyc;
  assign bus.wbs_stb_i = m_stb;
  assign bus.wbs_we_i  = m_we;
  assign bus.wbs_sel_i = m_sel;
  assign bus.wbs_adr_i = m_adr;
  assign bus.wbs_dat_i = m_dat;
  assign bus.s0_ack_i  = s_ack[0] | spur[0];
  assign bus.s1_ack_i  = s_ack[1] | spur[1];
  assign bus.s0_dat_i  = s_dat[0];
  assign bus.s1_dat_i  = s_dat[1];

  logic [1:0]  o_cyc, o_stb, o_we;
  logic [3:0]  o_sel [2];
  logic [31:0] o_adr [2], o_dat [2];
  assign o_cyc    = {bus.s1_cyc_o, bus.s0_cyc_o};
  assign o_stb    = {bus.s1_stb_o, bus.s0_stb_o};
  assign o_we     = {bus.s1_we_o, bus.s0_we_o};
  assign o_sel[0] = bus.s0_sel_o;
  assign o_sel[1] = bus.s1_sel_o;
  assign o_adr[0] = bus.s0_adr_o;
  assign o_adr[1] = bus.s1_adr_o;
  assign o_dat[0] = bus.s0_dat_o;
  assign o_dat[1] = bus.s1_dat_o;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Address map as stated: slave 0 has priority, anything else is a miss.
  function automatic int decode(input logic [31:0] a);
    if ((a & MASK) == (S0B & MASK)) return 0;
    if ((a & MASK) == (S1B & MASK)) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] slv_word(input int k, input logic [31:0] a);
    return a ^ ((k == 0) ? SALT0 : SALT1);
  endfunction

  // Slave models: check the registered request on the first strobe cycle, ack after lat[k] cycles.
  initial begin : slaves
    int   cnt [2];
    bit   acked [2];
    req_t r;
    cnt   = '{0, 0};
    acked = '{0, 0};
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        s_ack[k] = 1'b0;
        s_dat[k] = 32'hFFFF_FFFF;
        if (o_cyc[k] && o_stb[k]) begin
          if (cnt[k] == 0) begin
            if (sq.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_strobe slave=%0d adr=%h required no strobe", k, o_adr[k]);
            end else begin
              r = sq.pop_front();
              chk("req_slave", 32'(k), 32'(r.k));
              chk("req_we",  32'(o_we[k]), 32'(r.we));
              chk("req_sel", 32'(o_sel[k]), 32'(r.sel));
              chk("req_adr", o_adr[k], r.adr);
              chk("req_dat", o_dat[k], r.dat);
            end
          end
          if (!acked[k] && cnt[k] == lat[k]) begin
            s_ack[k] = 1'b1;
            s_dat[k] = slv_word(k, o_adr[k]);
            acked[k] = 1'b1;
          end
          cnt[k]++;
        end else begin
          if (cnt[k] != 0) stb_run[k] = cnt[k];
          cnt[k]   = 0;
          acked[k] = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      chk("one_slave_stb", 32'(o_stb[0] & o_stb[1]), 32'd0);
      if (bus.wbs_ack_o) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack dat=%h required no ack", bus.wbs_dat_o);
        end else begin
          e = rq.pop_front();
          chk("ack_dat", bus.wbs_dat_o, e.dat);
          chk("ack_timeout", 32'(bus.timeout_o), 32'(e.to));
        end
      end else begin
        chk("dat_without_ack", bus.wbs_dat_o, 32'd0);
        chk("timeout_without_ack", 32'(bus.timeout_o), 32'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input int l);
    int    k;
    resp_t e;
    req_t  r;
    k = decode(a);
    if (k < 0) begin
      e.dat = 32'hBADA_DD00;
      e.to  = 1'b0;
    end else begin
      r.k = k; r.we = w; r.sel = s; r.adr = a; r.dat = d;
      sq.push_back(r);
      lat[k] = l;
      e.dat = slv_word(k, a);
      e.to  = 1'b0;
`ifdef WB_MUX_TIMEOUT_EN
      if (l >= TMO) begin
        e.dat = 32'hDEAD_BEEF;
        e.to  = 1'b1;
      end
`endif
    end
    rq.push_back(e);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = w; m_sel = s; m_adr = a; m_dat = d;
  endtask

  task automatic wait_ack(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wbs_ack_o && n < 400);
    checks++;
    if (!bus.wbs_ack_o) begin
      errors++;
      $display("FAIL %s_ack_wait actual=no ack after %0d cycles required=ack", nm, n);
    end
    m_cyc = 1'b0;
    m_stb = 1'b0;
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input int l, input string nm);
    issue(a, w, d, s, l);
    wait_ack(nm);
  endtask

  // Queue a slave request with no master response expected, then wait for its strobe.
  task automatic start_no_resp(input int k, input logic [31:0] a, input string nm);
    req_t r;
    int   n;
    r.k = k; r.we = 1'b0; r.sel = 4'hF; r.adr = a; r.dat = 32'h0;
    sq.push_back(r);
    lat[k] = 1000;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_sel = 4'hF; m_adr = a; m_dat = 32'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_stb[k] && n < 20);
    checks++;
    if (!o_stb[k]) begin
      errors++;
      $display("FAIL %s_strobe_wait actual=no strobe required=strobe on slave %0d", nm, k);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] a, off;
    int          l, r;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    chk("rst_dat", bus.wbs_dat_o, 32'd0);
    chk("rst_s0_cyc", 32'(bus.s0_cyc_o), 32'd0);
    chk("rst_s1_stb", 32'(bus.s1_stb_o), 32'd0);
    chk("rst_s0_adr", bus.s0_adr_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed reads, writes and a decode miss.
    xfer(32'h3000_0010, 1'b0, 32'h0, 4'hF, 1, "rd_s0");
    xfer(32'h3010_0004, 1'b1, 32'hA5A5_A5A5, 4'hF, 0, "wr_s1");
    xfer(32'h2000_0000, 1'b0, 32'h0, 4'hF, 0, "miss");
    xfer(32'h300F_FFFC, 1'b1, 32'h0BAD_F00D, 4'h3, 0, "s0_top");
    xfer(32'h3020_0000, 1'b0, 32'h0, 4'hF, 0, "miss_adjacent");

`ifdef WB_MUX_TIMEOUT_EN
    xfer(32'h3000_0040, 1'b0, 32'h0, 4'hF, 1000, "timeout");
    @(negedge clk);
    chk("timeout_stb_cycles", 32'(stb_run[0]), 32'(TMO));
    xfer(32'h3010_0040, 1'b0, 32'h0, 4'hF, TMO - 1, "ack_at_limit");
`endif

    // Master abort in ACTIVE, late ack, then a normal read to slave 1.
    start_no_resp(0, 32'h3000_0020, "abort");
    @(negedge clk);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    chk("abort_s0_stb", 32'(bus.s0_stb_o), 32'd0);
    chk("abort_s0_cyc", 32'(bus.s0_cyc_o), 32'd0);
    spur[0] = 1'b1;
    @(negedge clk);
    spur[0] = 1'b0;
    repeat (3) @(negedge clk);
    xfer(32'h3010_0100, 1'b0, 32'h0, 4'hF, 2, "after_abort");

    // Reset in ACTIVE, then a spurious ack in IDLE.
    start_no_resp(1, 32'h3010_0200, "rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_ack", 32'(bus.wbs_ack_o), 32'd0);
    chk("rstmid_s1_cyc", 32'(bus.s1_cyc_o), 32'd0);
    chk("rstmid_s1_stb", 32'(bus.s1_stb_o), 32'd0);
    chk("rstmid_s1_adr", bus.s1_adr_o, 32'd0);
    chk("rstmid_s1_sel", 32'(bus.s1_sel_o), 32'd0);
    m_cyc = 1'b0; m_stb = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    spur[1] = 1'b1;
    @(negedge clk);
    spur[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_s1_stb", 32'(bus.s1_stb_o), 32'd0);

    // Randomized mix of slave 0, slave 1 and unmapped addresses.
    for (int i = 0; i < 40; i++) begin
      r   = int'($urandom_range(0, 2));
      off = $urandom & ~MASK;
      if (r == 0) a = S0B | off;
      else if (r == 1) a = S1B | off;
      else begin
        a = $urandom;
        while (decode(a) >= 0) a = $urandom;
      end
      l = int'($urandom_range(0, 4));
`ifdef WB_MUX_TIMEOUT_EN
      if ($urandom_range(0, 4) == 0) l = int'($urandom_range(TMO - 1, TMO + 2));
`endif
      xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), l, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    chk("req_queue_drained", 32'(sq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
